hazard_stall_unit: RTL and testbench

- Companion to the pipeline forwarding logic. It handles every hazard that bypassing cannot resolve: load-use dependencies, taken-branch flushes and data-memory wait states.
- It sits beside the ID stage. It drives the PC/IF_ID write enables, the ID_EX and IF_ID flushes, and the EX_MEM/MEM_WB freeze.
- It uses a small FSM with a bubble counter and a saved return state.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_perf_counters.sv | 41 ++++
 rtl/hazard_stall_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and state encodings for the hazard/stall unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } stall_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating event counters for load stalls, memory freezes and branch flushes.
module hazard_perf_counters
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_stall,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [PERF_W-1:0] perf_load_stalls,
  output logic [PERF_W-1:0] perf_mem_stalls,
  output logic [PERF_W-1:0] perf_flushes
);

  logic [PERF_W-1:0] load_q, load_d;
  logic [PERF_W-1:0] mem_q, mem_d;
  logic [PERF_W-1:0] flush_q, flush_d;

  always_comb begin
    load_d  = load_stall ? sat_inc(load_q) : load_q;
    mem_d   = mem_stall ? sat_inc(mem_q) : mem_q;
    flush_d = flush ? sat_inc(flush_q) : flush_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= '0;
      mem_q   <= '0;
      flush_q <= '0;
    end else begin
      load_q  <= load_d;
      mem_q   <= mem_d;
      flush_q <= flush_d;
    end
  end

  assign perf_load_stalls = load_q;
  assign perf_mem_stalls  = mem_q;
  assign perf_flushes     = flush_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller for load-use, taken-branch and data-memory wait hazards.
// Optional HAZARD_PERF_EN adds saturating performance counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_uses_rs,
  input  logic        IF_ID_uses_rt,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rt,
  input  logic        branch_taken,
  input  logic        EX_MEM_mem_access,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        back_freeze,
  output logic [1:0]  stall_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_load_stalls,
  output logic [PERF_W-1:0] perf_mem_stalls,
  output logic [PERF_W-1:0] perf_flushes
`endif
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_q, ret_d;
  logic [1:0]       eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mem_busy;

  assign load_use = ID_EX_mem_read && (ID_EX_rt != REG_ZERO) &&
                    ((IF_ID_uses_rs && (IF_ID_rs == ID_EX_rt)) ||
                     (IF_ID_uses_rt && (IF_ID_rt == ID_EX_rt)));
  assign mem_busy = EX_MEM_mem_access && !dmem_ready;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    back_freeze = 1'b0;
    // On the ready cycle MEM_WAIT behaves exactly like the state it interrupted.
    eff_state   = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    if (mem_busy) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      back_freeze = 1'b1;
      if (state_q == ST_RUN || state_q == ST_LOAD_STALL) begin
        state_d = ST_MEM_WAIT;
        ret_d   = state_q;
      end else if (state_q != ST_MEM_WAIT) begin
        state_d = ST_RUN;
      end
    end else begin
      ret_d = ST_RUN;
      case (eff_state)
        ST_LOAD_STALL: begin
          if (branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
          end else begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
            state_d     = (cnt_q <= CNT_W'(1)) ? ST_RUN : ST_LOAD_STALL;
          end
        end
        default: begin
          state_d = ST_RUN;
          if (branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = ST_LOAD_STALL;
              cnt_d   = CNT_W'(LOAD_USE_BUBBLES - 1);
            end
          end
        end
      endcase
    end

    // Outputs take their reset values as soon as reset rises, not at the next edge.
    if (reset) begin
      pc_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      back_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_state = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_counters u_perf (
    .clk              (clk),
    .reset            (reset),
    .load_stall       (!pc_write && !back_freeze),
    .mem_stall        (back_freeze),
    .flush            (IF_ID_flush),
    .perf_load_stalls (perf_load_stalls),
    .perf_mem_stalls  (perf_mem_stalls),
    .perf_flushes     (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: one instance with 1 load-use bubble, one with 3.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       mac;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [6:0] exp;
    string      name;
  } sb_t;

  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, back_freeze, stall_state}
  localparam logic [6:0] RUN_OK = 7'b1100000;
  localparam logic [6:0] LS_RUN = 7'b0001000;
  localparam logic [6:0] LS_LS  = 7'b0001001;
  localparam logic [6:0] LS_MW  = 7'b0001010;
  localparam logic [6:0] BR_RUN = 7'b1111000;
  localparam logic [6:0] BR_LS  = 7'b1111001;
  localparam logic [6:0] FRZ_R  = 7'b0000100;
  localparam logic [6:0] FRZ_LS = 7'b0000101;
  localparam logic [6:0] FRZ_MW = 7'b0000110;
  localparam logic [6:0] OK_MW  = 7'b1100010;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic IF_ID_uses_rs, IF_ID_uses_rt, ID_EX_mem_read, branch_taken;
  logic EX_MEM_mem_access, dmem_ready;

  logic pcw_a, ifw_a, iff_a, ief_a, frz_a;
  logic pcw_c, ifw_c, iff_c, ief_c, frz_c;
  logic [1:0] st_a, st_c;
  logic [6:0] out_a, out_c;
`ifdef HAZARD_PERF_EN
  logic [31:0] pl_a, pm_a, pf_a, pl_c, pm_c, pf_c;
`endif

  int checks = 0;
  int passed = 0;
  sb_t sbq[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  assign out_a = {pcw_a, ifw_a, iff_a, ief_a, frz_a, st_a};
  assign out_c = {pcw_c, ifw_c, iff_c, ief_c, frz_c, st_c};

  hazard_stall_unit #(.LOAD_USE_BUBBLES(1), .CNT_W(2)) dut_a (
    .clk               (clk),
    .reset             (reset),
    .IF_ID_rs          (IF_ID_rs),
    .IF_ID_rt          (IF_ID_rt),
    .IF_ID_uses_rs     (IF_ID_uses_rs),
    .IF_ID_uses_rt     (IF_ID_uses_rt),
    .ID_EX_mem_read    (ID_EX_mem_read),
    .ID_EX_rt          (ID_EX_rt),
    .branch_taken      (branch_taken),
    .EX_MEM_mem_access (EX_MEM_mem_access),
    .dmem_ready        (dmem_ready),
    .pc_write          (pcw_a),
    .IF_ID_write       (ifw_a),
    .IF_ID_flush       (iff_a),
    .ID_EX_flush       (ief_a),
    .back_freeze       (frz_a),
    .stall_state       (st_a)
`ifdef HAZARD_PERF_EN
    ,
    .perf_load_stalls  (pl_a),
    .perf_mem_stalls   (pm_a),
    .perf_flushes      (pf_a)
`endif
  );

  hazard_stall_unit #(.LOAD_USE_BUBBLES(3), .CNT_W(2)) dut_c (
    .clk               (clk),
    .reset             (reset),
    .IF_ID_rs          (IF_ID_rs),
    .IF_ID_rt          (IF_ID_rt),
    .IF_ID_uses_rs     (IF_ID_uses_rs),
    .IF_ID_uses_rt     (IF_ID_uses_rt),
    .ID_EX_mem_read    (ID_EX_mem_read),
    .ID_EX_rt          (ID_EX_rt),
    .branch_taken      (branch_taken),
    .EX_MEM_mem_access (EX_MEM_mem_access),
    .dmem_ready        (dmem_ready),
    .pc_write          (pcw_c),
    .IF_ID_write       (ifw_c),
    .IF_ID_flush       (iff_c),
    .ID_EX_flush       (ief_c),
    .back_freeze       (frz_c),
    .stall_state       (st_c)
`ifdef HAZARD_PERF_EN
    ,
    .perf_load_stalls  (pl_c),
    .perf_mem_stalls   (pm_c),
    .perf_flushes      (pf_c)
`endif
  );

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                             input logic urt, input logic mr, input logic [4:0] ert,
                             input logic br, input logic mac, input logic rdy);
    in_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
    v.ert = ert; v.br = br; v.mac = mac; v.rdy = rdy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    IF_ID_rs          = v.rs;
    IF_ID_rt          = v.rt;
    IF_ID_uses_rs     = v.urs;
    IF_ID_uses_rt     = v.urt;
    ID_EX_mem_read    = v.mr;
    ID_EX_rt          = v.ert;
    branch_taken      = v.br;
    EX_MEM_mem_access = v.mac;
    dmem_ready        = v.rdy;
  endtask

  task automatic sample();
    sb_t e;
    logic [6:0] got;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = e.sel ? out_c : out_a;
      checks++;
      if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
      else passed++;
    end
  endtask

  task automatic expect_both(input string name, input logic ca, input logic [6:0] ea,
                             input logic cc, input logic [6:0] ec);
    if (ca) sbq.push_back('{sel: 1'b0, exp: ea, name: {name, "/b1"}});
    if (cc) sbq.push_back('{sel: 1'b1, exp: ec, name: {name, "/b3"}});
  endtask

  task automatic step(input in_t v, input string name, input logic ca, input logic [6:0] ea,
                      input logic cc, input logic [6:0] ec);
    apply(v);
    expect_both(name, ca, ea, cc, ec);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else passed++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply('0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_t idle, lu, busy, rdy;
    idle = '0;
    lu   = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    busy = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    rdy  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    tbl[0]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0), RUN_OK, "idle"};
    tbl[1]  = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0), LS_RUN, "lu_rs"};
    tbl[2]  = '{mk(5'd0, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0), LS_RUN, "lu_rt"};
    tbl[3]  = '{mk(5'd0, 5'd5, 0, 0, 1, 5'd5, 0, 0, 0), RUN_OK, "rt_unused"};
    tbl[4]  = '{mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0), RUN_OK, "reg_zero"};
    tbl[5]  = '{mk(5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 0, 0), RUN_OK, "no_load"};
    tbl[6]  = '{mk(5'd5, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0), LS_RUN, "rs_off_rt_hit"};
    tbl[7]  = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0), BR_RUN, "br_with_lu"};
    tbl[8]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0), BR_RUN, "br_only"};
    tbl[9]  = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 1), LS_RUN, "mem_ready_lu"};
    tbl[10] = '{mk(5'd6, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0), RUN_OK, "rs_mismatch"};
    tbl[11] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0), FRZ_R, "busy_over_br"};
    tbl[12] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1), OK_MW, "ready_run"};
    tbl[13] = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0), FRZ_R, "busy_over_lu"};
    tbl[14] = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 1), LS_MW, "ready_lu"};
    tbl[15] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0), RUN_OK, "back_to_run"};

    reset = 1'b1;
    apply(lu);
    #3;
    expect_both("reset_vals", 1'b1, RUN_OK, 1'b1, RUN_OK);
    sample();
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(idle);

    for (int i = 0; i < 16; i++) step(tbl[i].in, tbl[i].name, 1'b1, tbl[i].exp, 1'b0, '0);

    // Three-bubble load-use: state shows LOAD_STALL for the last two.
    do_reset();
    step(lu,   "lu3_c1", 1'b1, LS_RUN, 1'b1, LS_RUN);
    step(idle, "lu3_c2", 1'b1, RUN_OK, 1'b1, LS_LS);
    step(idle, "lu3_c3", 1'b1, RUN_OK, 1'b1, LS_LS);
    step(idle, "lu3_c4", 1'b1, RUN_OK, 1'b1, RUN_OK);

    // Memory wait interrupting the last load-use bubble.
    do_reset();
    step(lu,   "mw_c1", 1'b1, LS_RUN, 1'b1, LS_RUN);
    step(idle, "mw_c2", 1'b1, RUN_OK, 1'b1, LS_LS);
    step(busy, "mw_c3", 1'b1, FRZ_R,  1'b1, FRZ_LS);
    step(busy, "mw_c4", 1'b1, FRZ_MW, 1'b1, FRZ_MW);
    step(busy, "mw_c5", 1'b1, FRZ_MW, 1'b1, FRZ_MW);
    step(busy, "mw_c6", 1'b1, FRZ_MW, 1'b1, FRZ_MW);
    step(rdy,  "mw_c7", 1'b1, OK_MW,  1'b1, LS_MW);
    step(idle, "mw_c8", 1'b1, RUN_OK, 1'b1, RUN_OK);

    // Illegal branch during LOAD_STALL still flushes and returns to RUN.
    do_reset();
    step(lu, "lsbr_c1", 1'b0, '0, 1'b1, LS_RUN);
    step(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0), "lsbr_c2", 1'b0, '0, 1'b1, BR_LS);
    step(idle, "lsbr_c3", 1'b0, '0, 1'b1, RUN_OK);

    // Mixed sequence exercising every counter, then async reset inside MEM_WAIT.
    do_reset();
    step(lu,   "mix_c1", 1'b0, '0, 1'b1, LS_RUN);
    step(idle, "mix_c2", 1'b0, '0, 1'b1, LS_LS);
    step(idle, "mix_c3", 1'b0, '0, 1'b1, LS_LS);
    step(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0), "mix_c4", 1'b0, '0, 1'b1, BR_RUN);
    step(busy, "mix_c5", 1'b0, '0, 1'b1, FRZ_R);
    step(busy, "mix_c6", 1'b0, '0, 1'b1, FRZ_MW);
`ifdef HAZARD_PERF_EN
    check_val("perf_load_b3", pl_c, 32'd3);
    check_val("perf_mem_b3",  pm_c, 32'd2);
    check_val("perf_flush_b3", pf_c, 32'd1);
`endif
    #2;
    reset = 1'b1;
    #1;
    expect_both("async_reset", 1'b1, RUN_OK, 1'b1, RUN_OK);
    sample();
`ifdef HAZARD_PERF_EN
    check_val("perf_load_rst", pl_c, 32'd0);
    check_val("perf_mem_rst",  pm_c, 32'd0);
    check_val("perf_flush_rst", pf_c, 32'd0);
    check_val("perf_mem_rst_a", pm_a, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(idle, "after_reset", 1'b1, RUN_OK, 1'b1, RUN_OK);
    check_val("sb_drained", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
